// File: rtl/memory_access_if.sv
// Data-memory bus between the M stage (master) and the data memory (slave).
// One request stays outstanding until the memory answers with dmem_ack_i.
interface memory_access_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [63:0] dmem_rdata_i;
    logic        dmem_err_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i, dmem_err_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i, dmem_err_i
    );
endinterface

// File: rtl/memory_access.sv
// Y86-64 memory stage: M pipeline register plus a two-state data-memory access FSM
// with address-range checking, bus-error handling and a request timeout.
module memory_access #(
    parameter logic [63:0] ADDR_LIMIT = 64'h0000_0000_0001_0000,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  memory_stall_i,
    input  logic                  memory_bubble_i,
    input  logic [3:0]            icode_i,
    input  logic [2:0]            stat_i,
    input  logic [63:0]           valE_i,
    input  logic [63:0]           valA_i,
    input  logic [3:0]            dstE_i,
    input  logic [3:0]            dstM_i,
    memory_access_if.master       dmem,
    output logic                  busy_o,
    output logic [3:0]            icode_o,
    output logic [2:0]            stat_o,
    output logic [63:0]           valE_o,
    output logic [63:0]           valM_o,
    output logic [3:0]            dstE_o,
    output logic [3:0]            dstM_o
);
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SADR    = 3'd3;

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state;
    logic [7:0]  count;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic        load;
    logic        needs_mem;
    logic        in_range;

    // Decode of the incoming instruction: direction and address source.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = valE_i;
        case (icode_i)
            IRMMOVQ, IPUSHQ, ICALL: mem_write = 1'b1;
            IMRMOVQ:                mem_read  = 1'b1;
            IPOPQ, IRET: begin
                mem_read = 1'b1;
                mem_addr = valA_i;
            end
            default: ;
        endcase
    end

    assign load      = !busy_o && !memory_stall_i;
    assign needs_mem = !memory_bubble_i && (mem_read || mem_write);
    assign in_range  = mem_addr < ADDR_LIMIT;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            count             <= 8'd0;
            busy_o            <= 1'b0;
            dmem.dmem_req_o   <= 1'b0;
            dmem.dmem_we_o    <= 1'b0;
            dmem.dmem_addr_o  <= 64'd0;
            dmem.dmem_wdata_o <= 64'd0;
            icode_o           <= INOP;
            stat_o            <= SAOK;
            valE_o            <= 64'd0;
            valM_o            <= 64'd0;
            dstE_o            <= RNONE;
            dstM_o            <= RNONE;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        if (memory_bubble_i) begin
                            icode_o <= INOP;
                            stat_o  <= SAOK;
                            valE_o  <= 64'd0;
                            dstE_o  <= RNONE;
                            dstM_o  <= RNONE;
                        end else begin
                            icode_o <= icode_i;
                            stat_o  <= stat_i;
                            valE_o  <= valE_i;
                            dstE_o  <= dstE_i;
                            dstM_o  <= dstM_i;
                            // Faulting addresses never reach the bus.
                            if (needs_mem && stat_i == SAOK) begin
                                if (in_range) begin
                                    state             <= REQ;
                                    count             <= 8'd0;
                                    busy_o            <= 1'b1;
                                    dmem.dmem_req_o   <= 1'b1;
                                    dmem.dmem_we_o    <= mem_write;
                                    dmem.dmem_addr_o  <= mem_addr;
                                    dmem.dmem_wdata_o <= mem_write ? valA_i : 64'd0;
                                end else begin
                                    stat_o <= SADR;
                                end
                            end
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_ack_i || count == TIMEOUT - 8'd1) begin
                        // An ack beats a timeout landing on the same cycle.
                        if (!dmem.dmem_ack_i || dmem.dmem_err_i) begin
                            stat_o <= SADR;
                        end else if (!dmem.dmem_we_o) begin
                            valM_o <= dmem.dmem_rdata_i;
                        end
                        state             <= IDLE;
                        busy_o            <= 1'b0;
                        dmem.dmem_req_o   <= 1'b0;
                        dmem.dmem_we_o    <= 1'b0;
                        dmem.dmem_addr_o  <= 64'd0;
                        dmem.dmem_wdata_o <= 64'd0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: a scoreboard of expected M-stage results
// plus a bus responder with configurable ack latency and error injection.
module tb_memory_access;
    localparam logic [63:0] ADDR_LIMIT = 64'h0000_0000_0001_0000;
    localparam logic [7:0]  TIMEOUT    = 8'd255;
    localparam logic [3:0]  INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3, IRMMOVQ = 4'h4;
    localparam logic [3:0]  IMRMOVQ = 4'h5, IOPQ = 4'h6, ICALL = 4'h8, IRET = 4'h9;
    localparam logic [3:0]  IPUSHQ = 4'hA, IPOPQ = 4'hB, RNONE = 4'hF;
    localparam logic [2:0]  SAOK = 3'd1, SADR = 3'd3, SINS = 3'd4;

    typedef struct packed {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memory_stall_i = 1'b0, memory_bubble_i = 1'b0;
    logic [3:0]  icode_i = INOP;
    logic [2:0]  stat_i = SAOK;
    logic [63:0] valE_i = '0, valA_i = '0;
    logic [3:0]  dstE_i = RNONE, dstM_i = RNONE;
    logic        busy_o;
    logic [3:0]  icode_o, dstE_o, dstM_o;
    logic [2:0]  stat_o;
    logic [63:0] valE_o, valM_o;

    memory_access_if dmem ();

    memory_access #(.ADDR_LIMIT(ADDR_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .memory_stall_i(memory_stall_i), .memory_bubble_i(memory_bubble_i),
        .icode_i(icode_i), .stat_i(stat_i), .valE_i(valE_i), .valA_i(valA_i),
        .dstE_i(dstE_i), .dstM_i(dstM_i), .dmem(dmem), .busy_o(busy_o),
        .icode_o(icode_o), .stat_o(stat_o), .valE_o(valE_o), .valM_o(valM_o),
        .dstE_o(dstE_o), .dstM_o(dstM_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    res_t        sb[$];
    res_t        last_exp;
    logic [63:0] model_valM = '0;

    function automatic res_t observe();
        return {icode_o, stat_o, valE_o, valM_o, dstE_o, dstM_o};
    endfunction

    // 2'b10 = write, 2'b01 = read, 2'b00 = no access.
    function automatic logic [1:0] mem_kind(input logic [3:0] icode);
        case (icode)
            IRMMOVQ, IPUSHQ, ICALL: return 2'b10;
            IMRMOVQ, IPOPQ, IRET:   return 2'b01;
            default:                return 2'b00;
        endcase
    endfunction

    // Issues one instruction, answers its bus request after lat REQ cycles
    // (lat = 0: never), then retires it against the scoreboard.
    task automatic run_instr(input logic [3:0] icode, input logic [2:0] stat,
                             input logic [63:0] valE, input logic [63:0] valA,
                             input logic [3:0] dstE, input logic [3:0] dstM,
                             input int lat, input logic err, input logic [63:0] rdata,
                             output int busy_cycles, output int req_cycles);
        logic [1:0]   kind;
        logic [63:0]  addr;
        logic [128:0] bus_exp;
        logic [128:0] bus_obs;
        res_t         exp;
        logic         done;
        kind = mem_kind(icode);
        addr = (icode == IPOPQ || icode == IRET) ? valA : valE;
        exp  = '{icode: icode, stat: stat, valE: valE, valM: 64'd0, dstE: dstE, dstM: dstM};
        if (kind != 2'b00 && stat == SAOK) begin
            if (addr >= ADDR_LIMIT || lat == 0 || err) exp.stat = SADR;
            else if (kind == 2'b01) model_valM = rdata;
        end
        exp.valM = model_valM;
        sb.push_back(exp);
        bus_exp = {kind[1], addr, kind[1] ? valA : 64'd0};

        @(negedge clk);
        icode_i = icode; stat_i = stat; valE_i = valE; valA_i = valA;
        dstE_i = dstE; dstM_i = dstM;
        memory_stall_i = 1'b0; memory_bubble_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        memory_stall_i = 1'b1;
        busy_cycles = 0;
        req_cycles  = 0;
        done        = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!busy_o) begin
                done = 1'b1;
                break;
            end
            busy_cycles++;
            if (dmem.dmem_req_o) begin
                req_cycles++;
                bus_obs = {dmem.dmem_we_o, dmem.dmem_addr_o,
                           dmem.dmem_we_o ? dmem.dmem_wdata_o : 64'd0};
                checks++;
                if (bus_obs !== bus_exp) begin
                    errors++;
                    $display("FAIL bus_fields icode=%0h: got %h want %h", icode, bus_obs, bus_exp);
                end
            end
            if (lat != 0 && busy_cycles == lat) begin
                dmem.dmem_ack_i = 1'b1; dmem.dmem_err_i = err; dmem.dmem_rdata_i = rdata;
            end else begin
                dmem.dmem_ack_i = 1'b0; dmem.dmem_err_i = 1'b0; dmem.dmem_rdata_i = '0;
            end
            @(negedge clk);
        end
        dmem.dmem_ack_i = 1'b0; dmem.dmem_err_i = 1'b0; dmem.dmem_rdata_i = '0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL busy_bound icode=%0h: busy still %b after 400 cycles, want 0", icode, busy_o);
        end
        exp = sb.pop_front();
        last_exp = exp;
        checks++;
        if (observe() !== exp) begin
            errors++;
            $display("FAIL retire icode=%0h: got %h want %h", icode, observe(), exp);
        end
        checks++;
        if ({dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wdata_o} !== 130'd0) begin
            errors++;
            $display("FAIL bus_idle icode=%0h: req=%b we=%b addr=%h wdata=%h want all 0", icode,
                     dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wdata_o);
        end
    endtask

    task automatic test_reset();
        res_t exp;
        rst = 1'b1;
        dmem.dmem_ack_i = 1'b0; dmem.dmem_err_i = 1'b0; dmem.dmem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        exp = '{icode: INOP, stat: SAOK, valE: 64'd0, valM: 64'd0, dstE: RNONE, dstM: RNONE};
        checks++;
        if (observe() !== exp) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", observe(), exp);
        end
        checks++;
        if ({busy_o, dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wdata_o} !== 131'd0) begin
            errors++;
            $display("FAIL reset_bus: busy=%b req=%b we=%b want 0", busy_o, dmem.dmem_req_o, dmem.dmem_we_o);
        end
        @(negedge clk);
        rst = 1'b0;
        model_valM = '0;
    endtask

    task automatic test_read_latency();
        int b, r;
        run_instr(IMRMOVQ, SAOK, 64'h100, 64'h0, RNONE, 4'h3, 3, 1'b0, 64'hDEAD_BEEF, b, r);
        checks++;
        if (b !== 3 || r !== 3) begin
            errors++;
            $display("FAIL read_latency: busy=%0d req=%0d want 3 and 3", b, r);
        end
    endtask

    task automatic test_push();
        int b, r;
        run_instr(IPUSHQ, SAOK, 64'h1F8, 64'h42, 4'h4, RNONE, 1, 1'b0, 64'h0, b, r);
        checks++;
        if (b !== 1 || r !== 1) begin
            errors++;
            $display("FAIL push_single_cycle: busy=%0d req=%0d want 1 and 1", b, r);
        end
    endtask

    task automatic test_addr_limit();
        int b, r;
        run_instr(IRMMOVQ, SAOK, ADDR_LIMIT, 64'h77, RNONE, RNONE, 1, 1'b0, 64'h0, b, r);
        checks++;
        if (b !== 0 || r !== 0) begin
            errors++;
            $display("FAIL addr_at_limit: busy=%0d req=%0d want 0 and 0", b, r);
        end
        run_instr(IMRMOVQ, SAOK, ADDR_LIMIT - 64'd8, 64'h0, RNONE, 4'h2, 2, 1'b0, 64'h1234_5678, b, r);
        checks++;
        if (b !== 2 || r !== 2) begin
            errors++;
            $display("FAIL addr_below_limit: busy=%0d req=%0d want 2 and 2", b, r);
        end
    endtask

    task automatic test_timeout();
        int b, r;
        run_instr(IPOPQ, SAOK, 64'h208, 64'h200, 4'h4, 4'h5, 0, 1'b0, 64'h0, b, r);
        checks++;
        if (r !== 255 || b !== 255) begin
            errors++;
            $display("FAIL timeout_length: req=%0d busy=%0d want 255 and 255", r, b);
        end
    endtask

    task automatic test_bus_error();
        int b, r;
        run_instr(IMRMOVQ, SAOK, 64'h300, 64'h0, RNONE, 4'h6, 2, 1'b1, 64'hBAD0_BAD0, b, r);
        checks++;
        if (b !== 2) begin
            errors++;
            $display("FAIL bus_error_busy: busy=%0d want 2", b);
        end
        run_instr(IMRMOVQ, SINS, 64'h400, 64'h0, RNONE, 4'h7, 1, 1'b0, 64'h5555, b, r);
        checks++;
        if (b !== 0 || r !== 0) begin
            errors++;
            $display("FAIL bad_stat_no_req: busy=%0d req=%0d want 0 and 0", b, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq[8] = '{IOPQ, ICALL, IRET, IRRMOVQ, IPUSHQ, IPOPQ, IMRMOVQ, IIRMOVQ};
        int b, r, lat, want;
        for (int i = 0; i < 8; i++) begin
            lat  = $urandom_range(1, 4);
            want = (mem_kind(seq[i]) != 2'b00) ? lat : 0;
            run_instr(seq[i], SAOK, 64'($urandom_range(0, 4095)) << 3, 64'($urandom_range(0, 4095)) << 3,
                      4'(i), 4'(i + 8), lat, 1'b0, {$urandom, $urandom}, b, r);
            checks++;
            if (b !== want) begin
                errors++;
                $display("FAIL back_to_back[%0d] busy: got %0d want %0d", i, b, want);
            end
        end
    endtask

    task automatic test_mid_reset();
        int b, r;
        res_t exp;
        @(negedge clk);
        icode_i = IMRMOVQ; stat_i = SAOK; valE_i = 64'h500; valA_i = 64'h0;
        dstE_i = RNONE; dstM_i = 4'h1; memory_stall_i = 1'b0; memory_bubble_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        memory_stall_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dmem.dmem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre: req=%b want 1", dmem.dmem_req_o);
        end
        #2 rst = 1'b1;
        #1;
        exp = '{icode: INOP, stat: SAOK, valE: 64'd0, valM: 64'd0, dstE: RNONE, dstM: RNONE};
        checks++;
        if ({dmem.dmem_req_o, busy_o, observe()} !== {2'b00, exp}) begin
            errors++;
            $display("FAIL mid_reset_async: req=%b busy=%b outs=%h want 0 0 %h",
                     dmem.dmem_req_o, busy_o, observe(), exp);
        end
        @(negedge clk);
        rst = 1'b0;
        model_valM = '0;
        run_instr(IOPQ, SAOK, 64'h0123_4567_89AB_CDEF, 64'h9, 4'h2, RNONE, 1, 1'b0, 64'h0, b, r);
        checks++;
        if (valE_o !== 64'h0123_4567_89AB_CDEF || b !== 0) begin
            errors++;
            $display("FAIL after_reset_opq: valE=%h busy=%0d want 0123456789abcdef and 0", valE_o, b);
        end
    endtask

    task automatic test_stall_bubble();
        res_t exp;
        @(negedge clk);
        icode_i = IOPQ; stat_i = SAOK; valE_i = 64'hCAFE; dstE_i = 4'h3; dstM_i = RNONE;
        memory_stall_i = 1'b1; memory_bubble_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (observe() !== last_exp) begin
            errors++;
            $display("FAIL stall_over_bubble: got %h want %h", observe(), last_exp);
        end
        @(negedge clk);
        memory_stall_i = 1'b0;
        exp = '{icode: INOP, stat: SAOK, valE: 64'd0, valM: model_valM, dstE: RNONE, dstM: RNONE};
        sb.push_back(exp);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if ({busy_o, observe()} !== {1'b0, exp}) begin
            errors++;
            $display("FAIL bubble_nop: busy=%b got %h want %h", busy_o, observe(), exp);
        end
        @(negedge clk);
        memory_stall_i = 1'b1; memory_bubble_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_push();
        test_addr_limit();
        test_timeout();
        test_bus_error();
        test_back_to_back();
        test_stall_bubble();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
